shared_path_arbiter: RTL and testbench

SHARED_PATH_ARBITER -- requirements
Module: shared_path_arbiter

---
 rtl/shared_path_arbiter_if.sv | 22 ++
 rtl/shared_path_arbiter.sv | 123 ++++++++++++
 tb/tb_shared_path_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shared_path_arbiter_if.sv
// rtl/shared_path_arbiter_if.sv - request/grant bundle between two requesters and the shared-path arbiter
interface shared_path_arbiter_if;
    logic req_a;
    logic req_b;
    logic done_a;
    logic done_b;
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;
    logic timeout;

    modport master (
        output req_a, req_b, done_a, done_b,
        input  gnt_a, gnt_b, sel, busy, timeout
    );

    modport slave (
        input  req_a, req_b, done_a, done_b,
        output gnt_a, gnt_b, sel, busy, timeout
    );
endinterface

// File: rtl/shared_path_arbiter.sv
// rtl/shared_path_arbiter.sv - two-requester round-robin arbiter with hold limit for a shared 2:1 path
module shared_path_arbiter #(
    parameter int   HOLD_MAX = 15,
    parameter logic IDLE_SEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_path_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Last cycle of a grant is the one whose counter value reaches HOLD_MAX-1.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       last_b_q, last_b_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       hold_limit;
    logic       release_a;
    logic       release_b;

    assign hold_limit = (hold_cnt_q == HOLD_LAST);
    assign release_a  = bus.done_a || !bus.req_a;
    assign release_b  = bus.done_b || !bus.req_b;

    // Next-state and registered-output computation; outputs are decoded from the next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_b_d   = last_b_q;
        sel_d      = sel_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A wins when alone, or on a tie when B was served last.
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d    = GRANT_A;
                    gnt_a_d    = 1'b1;
                    sel_d      = 1'b1;
                    last_b_d   = 1'b0;
                    hold_cnt_d = 8'd0;
                end else if (bus.req_b) begin
                    state_d    = GRANT_B;
                    gnt_b_d    = 1'b1;
                    sel_d      = 1'b0;
                    last_b_d   = 1'b1;
                    hold_cnt_d = 8'd0;
                end
            end
            GRANT_A: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (release_a || hold_limit) begin
                    state_d   = GAP;
                    timeout_d = hold_limit && !release_a;
                end else begin
                    gnt_a_d = 1'b1;
                end
            end
            GRANT_B: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (release_b || hold_limit) begin
                    state_d   = GAP;
                    timeout_d = hold_limit && !release_b;
                end else begin
                    gnt_b_d = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any grant immediately without a GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            last_b_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            sel_q      <= IDLE_SEL;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_b_q   <= last_b_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt_a   = gnt_a_q;
    assign bus.gnt_b   = gnt_b_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_shared_path_arbiter.sv
// tb/tb_shared_path_arbiter.sv - self-checking bench for shared_path_arbiter
module tb_shared_path_arbiter;

    localparam int   HOLD      = 4;
    localparam logic IDLE_SEL  = 1'b0;
    localparam int   NVEC      = 36;

    logic clk;
    logic rst;
    int   tests;
    int   errors;
    int   cyc;

    shared_path_arbiter_if bus ();

    shared_path_arbiter #(
        .HOLD_MAX (HOLD),
        .IDLE_SEL (IDLE_SEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: owner 0=none 1=A 2=B, held = grant cycles elapsed.
    int m_owner;
    bit m_gap;
    int m_held;
    int m_last;
    bit m_sel;
    bit m_to;

    task automatic model_step(input bit r, input bit ra, input bit rb, input bit da, input bit db);
        bit my_req;
        bit my_done;
        bit rel;
        bit lim;
        int want;
        m_to = 1'b0;
        if (r) begin
            m_owner = 0;
            m_gap   = 1'b0;
            m_held  = 0;
            m_last  = 2;
            m_sel   = IDLE_SEL;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner != 0) begin
            my_req  = (m_owner == 1) ? ra : rb;
            my_done = (m_owner == 1) ? da : db;
            rel = my_done || !my_req;
            lim = (m_held == HOLD);
            if (rel || lim) begin
                m_to    = lim && !rel;
                m_owner = 0;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            if (ra && rb)  want = (m_last == 1) ? 2 : 1;
            else if (ra)   want = 1;
            else if (rb)   want = 2;
            else           want = 0;
            if (want != 0) begin
                m_owner = want;
                m_held  = 1;
                m_last  = want;
                m_sel   = (want == 1);
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model with them, then compare after the edge.
    task automatic cycle(input bit r, input bit ra, input bit rb, input bit da, input bit db);
        rst        = r;
        bus.req_a  = ra;
        bus.req_b  = rb;
        bus.done_a = da;
        bus.done_b = db;
        @(posedge clk);
        model_step(r, ra, rb, da, db);
        cyc++;
        #1;
        check("model.gnt_a",   bus.gnt_a,   m_owner == 1);
        check("model.gnt_b",   bus.gnt_b,   m_owner == 2);
        check("model.sel",     bus.sel,     m_sel);
        check("model.busy",    bus.busy,    (m_owner != 0) || m_gap);
        check("model.timeout", bus.timeout, m_to);
        check("gnt_exclusive", bus.gnt_a & bus.gnt_b, 1'b0);
    endtask

    typedef struct packed {
        logic r, ra, rb, da, db;
        logic ga, gb, sel, busy, to;
    } vec_t;

    vec_t tbl [NVEC];

    bit ra_r, rb_r;
    int exp_owner;
    int waited;

    initial begin
        tests  = 0;
        errors = 0;
        cyc    = 0;
        rst        = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.done_a = 1'b0;
        bus.done_b = 1'b0;
        m_owner = 0; m_gap = 0; m_held = 0; m_last = 2; m_sel = IDLE_SEL; m_to = 0;

        // inputs {rst,req_a,req_b,done_a,done_b}, outputs {gnt_a,gnt_b,sel,busy,timeout}
        tbl[0]  = {5'b10000, 5'b00000};   // reset
        tbl[1]  = {5'b01000, 5'b10110};   // single A request
        tbl[2]  = {5'b01001, 5'b10110};   // stray done_b during grant A
        tbl[3]  = {5'b01000, 5'b10110};
        tbl[4]  = {5'b01010, 5'b00110};   // done_a -> GAP
        tbl[5]  = {5'b00000, 5'b00100};   // IDLE, sel held
        tbl[6]  = {5'b00010, 5'b00100};   // stray done_a in IDLE
        tbl[7]  = {5'b00001, 5'b00100};   // stray done_b in IDLE
        tbl[8]  = {5'b01000, 5'b10110};   // grant A cycle 1
        tbl[9]  = {5'b01000, 5'b10110};
        tbl[10] = {5'b01000, 5'b10110};
        tbl[11] = {5'b01000, 5'b10110};   // cycle 4
        tbl[12] = {5'b01010, 5'b00110};   // done with limit: no timeout
        tbl[13] = {5'b00000, 5'b00100};
        tbl[14] = {5'b00100, 5'b01010};   // grant B cycle 1
        tbl[15] = {5'b00100, 5'b01010};
        tbl[16] = {5'b00100, 5'b01010};
        tbl[17] = {5'b00100, 5'b01010};   // cycle 4
        tbl[18] = {5'b01100, 5'b00011};   // hold limit -> timeout in GAP
        tbl[19] = {5'b01100, 5'b00000};   // IDLE
        tbl[20] = {5'b01100, 5'b10110};   // tie after B timeout -> A
        tbl[21] = {5'b01110, 5'b00110};
        tbl[22] = {5'b00100, 5'b00100};
        tbl[23] = {5'b00100, 5'b01010};
        tbl[24] = {5'b00101, 5'b00010};
        tbl[25] = {5'b00000, 5'b00000};
        tbl[26] = {5'b00100, 5'b01010};   // grant B cycle 1
        tbl[27] = {5'b00100, 5'b01010};   // cycle 2
        tbl[28] = {5'b11100, 5'b00000};   // reset mid-grant, no GAP
        tbl[29] = {5'b01100, 5'b10110};   // tie after reset -> A
        tbl[30] = {5'b01110, 5'b00110};
        tbl[31] = {5'b00000, 5'b00100};
        tbl[32] = {5'b01000, 5'b10110};   // A served last
        tbl[33] = {5'b11000, 5'b00000};   // reset restores sel and pointer
        tbl[34] = {5'b01100, 5'b10110};   // tie -> A despite A served before reset
        tbl[35] = {5'b10000, 5'b00000};

        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].r, tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db);
            check($sformatf("tbl[%0d].gnt_a", i),   bus.gnt_a,   tbl[i].ga);
            check($sformatf("tbl[%0d].gnt_b", i),   bus.gnt_b,   tbl[i].gb);
            check($sformatf("tbl[%0d].sel", i),     bus.sel,     tbl[i].sel);
            check($sformatf("tbl[%0d].busy", i),    bus.busy,    tbl[i].busy);
            check($sformatf("tbl[%0d].timeout", i), bus.timeout, tbl[i].to);
        end

        // Round-robin with continuous tie, done on each grant's 2nd cycle.
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            exp_owner = (k % 2 == 0) ? 1 : 2;
            waited = 0;
            while (!(bus.gnt_a || bus.gnt_b) && waited < 6) begin
                cycle(0, 1, 1, 0, 0);
                waited++;
            end
            check($sformatf("rr[%0d].granted", k), bus.gnt_a || bus.gnt_b, 1'b1);
            check($sformatf("rr[%0d].owner_a", k), bus.gnt_a, exp_owner == 1);
            check($sformatf("rr[%0d].sel", k),     bus.sel,   exp_owner == 1);
            cycle(0, 1, 1, 0, 0);
            check($sformatf("rr[%0d].cycle2", k), bus.gnt_a || bus.gnt_b, 1'b1);
            cycle(0, 1, 1, exp_owner == 1, exp_owner == 2);
            check($sformatf("rr[%0d].gap_busy", k), bus.busy, 1'b1);
            check($sformatf("rr[%0d].gap_gnt", k),  bus.gnt_a || bus.gnt_b, 1'b0);
        end

        // Randomized traffic against the reference model.
        ra_r = 0;
        rb_r = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(5) == 0) ra_r = ~ra_r;
            if ($urandom_range(5) == 0) rb_r = ~rb_r;
            cycle($urandom_range(49) == 0, ra_r, rb_r,
                  $urandom_range(4) == 0, $urandom_range(4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
